// File: rtl/cdb_arbiter_if.sv
// Common Data Bus request/broadcast bundle.
// Requesters drive master; the arbiter takes slave.
interface cdb_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32
) ();
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*TAG_W-1:0]  req_tag;
  logic [N_REQ*DATA_W-1:0] req_value;
  logic [N_REQ-1:0]        req_ready;
  logic                    broadcast_valid;
  logic [TAG_W-1:0]        broadcast_tag;
  logic [DATA_W-1:0]       broadcast_value;
  logic [ID_W-1:0]         broadcast_src;
  logic                    err_tag0;

  modport master (
    output req_valid, req_tag, req_value,
    input  req_ready, broadcast_valid, broadcast_tag,
    input  broadcast_value, broadcast_src, err_tag0
  );

  modport slave (
    input  req_valid, req_tag, req_value,
    output req_ready, broadcast_valid, broadcast_tag,
    output broadcast_value, broadcast_src, err_tag0
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter with one-cycle registered broadcast.
// Tag-0 requests are drained immediately and flagged sticky.
module cdb_arbiter #(
  parameter int N_REQ  = 4,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32
) (
  input logic         clk,
  input logic         reset,
  cdb_arbiter_if.slave bus
);
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   win;
  logic              found;
  logic [TAG_W-1:0]  win_tag;
  logic [DATA_W-1:0] win_val;
  logic [N_REQ-1:0]  elig;
  logic [N_REQ-1:0]  drain;
  logic [N_REQ-1:0]  ready;
  int                idx;

  logic              bc_valid;
  logic [TAG_W-1:0]  bc_tag;
  logic [DATA_W-1:0] bc_value;
  logic [ID_W-1:0]   bc_src;
  logic              err;

  always_comb begin
    elig  = '0;
    drain = '0;
    for (int i = 0; i < N_REQ; i++) begin
      elig[i]  = bus.req_valid[i] &&
                 (bus.req_tag[i*TAG_W +: TAG_W] != '0);
      drain[i] = bus.req_valid[i] &&
                 (bus.req_tag[i*TAG_W +: TAG_W] == '0);
    end
  end

  // first eligible requester at or after rr_ptr, wrapping
  always_comb begin
    found   = 1'b0;
    win     = '0;
    win_tag = '0;
    win_val = '0;
    idx     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (!found && elig[idx]) begin
        found   = 1'b1;
        win     = ID_W'(idx);
        win_tag = bus.req_tag[idx*TAG_W +: TAG_W];
        win_val = bus.req_value[idx*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    ready = '0;
    if (reset) begin
      ready = drain;
      if (found) ready[win] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr   <= '0;
      bc_valid <= 1'b0;
      bc_tag   <= '0;
      bc_value <= '0;
      bc_src   <= '0;
      err      <= 1'b0;
    end else begin
      err <= err | (|drain);
      if (found) begin
        bc_valid <= 1'b1;
        bc_tag   <= win_tag;
        bc_value <= win_val;
        bc_src   <= win;
        rr_ptr   <= (win == ID_W'(N_REQ - 1)) ? '0 : win + 1'b1;
      end else begin
        bc_valid <= 1'b0;
        bc_tag   <= '0;
        bc_value <= '0;
        bc_src   <= '0;
      end
    end
  end

  assign bus.req_ready       = ready;
  assign bus.broadcast_valid = bc_valid;
  assign bus.broadcast_tag   = bc_tag;
  assign bus.broadcast_value = bc_value;
  assign bus.broadcast_src   = bc_src;
  assign bus.err_tag0        = err;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: driver queues expected
// broadcasts, a negedge monitor pops and compares them.
module tb_cdb_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int total = 0;
  int bad = 0;

  typedef struct {
    logic [3:0]  tag;
    logic [31:0] val;
    logic [1:0]  src;
  } exp_t;

  exp_t q[$];

  cdb_arbiter_if #(.N_REQ(4), .TAG_W(4), .DATA_W(32)) bus ();

  cdb_arbiter #(.N_REQ(4), .TAG_W(4), .DATA_W(32)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // one arbitration cycle; src < 0 means no grant expected
  task automatic cyc(input logic [3:0] v, input logic [15:0] tg,
                     input logic [127:0] vl, input logic [3:0] rdy,
                     input int src, input logic er);
    exp_t e;
    @(negedge clk);
    bus.req_valid = v;
    bus.req_tag   = tg;
    bus.req_value = vl;
    #1;
    chk("req_ready", 32'(bus.req_ready), 32'(rdy));
    chk("err_tag0", 32'(bus.err_tag0), 32'(er));
    if (src >= 0) begin
      e.tag = tg[src*4 +: 4];
      e.val = vl[src*32 +: 32];
      e.src = 2'(src);
      q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.broadcast_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_bcast", 32'(bus.broadcast_tag), 32'h0);
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("bc_tag", 32'(bus.broadcast_tag), 32'(e.tag));
        chk("bc_value", bus.broadcast_value, e.val);
        chk("bc_src", 32'(bus.broadcast_src), 32'(e.src));
      end
    end else begin
      chk("idle_bus", {bus.broadcast_value[27:0],
                       bus.broadcast_tag} |
                      32'(bus.broadcast_src), 32'h0);
    end
  end

  localparam logic [127:0] V0 = '0;
  localparam logic [127:0] VA =
    {32'h4444_0004, 32'h3333_0003, 32'h2222_0002, 32'h1111_0001};

  initial begin
    int budget;
    bus.req_valid = 4'b1111;
    bus.req_tag   = 16'h4321;
    bus.req_value = VA;
    #3;
    chk("rst_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_valid", 32'(bus.broadcast_valid), 32'h0);
    chk("rst_err", 32'(bus.err_tag0), 32'h0);
    bus.req_valid = '0;
    #10 reset = 1'b1;

    repeat (5) cyc(4'b0000, 16'h0, V0, 4'b0000, -1, 1'b0);

    cyc(4'b0010, 16'h0050, {32'h0, 32'h0, 32'hDEAD_BEEF, 32'h0},
        4'b0010, 1, 1'b0);
    cyc(4'b0100, 16'h0600, {32'h0, 32'h66, 32'h0, 32'h0},
        4'b0100, 2, 1'b0);
    cyc(4'b1001, 16'hA009, {32'hAAAA, 32'h0, 32'h0, 32'h9999},
        4'b1000, 3, 1'b0);
    cyc(4'b0001, 16'hA009, {32'hAAAA, 32'h0, 32'h0, 32'h9999},
        4'b0001, 0, 1'b0);
    cyc(4'b1000, 16'hB000, {32'hB0, 32'h0, 32'h0, 32'h0},
        4'b1000, 3, 1'b0);

    cyc(4'b1111, 16'h4321, VA, 4'b0001, 0, 1'b0);
    cyc(4'b1111, 16'h4321, VA, 4'b0010, 1, 1'b0);
    cyc(4'b1111, 16'h4321, VA, 4'b0100, 2, 1'b0);
    cyc(4'b1111, 16'h4321, VA, 4'b1000, 3, 1'b0);
    cyc(4'b1111, 16'h4321, VA, 4'b0001, 0, 1'b0);

    cyc(4'b0101, 16'h0700, {32'h0, 32'h77, 32'h0, 32'h5},
        4'b0101, 2, 1'b0);
    cyc(4'b0000, 16'h0, V0, 4'b0000, -1, 1'b1);
    cyc(4'b1011, 16'h8000, {32'h88, 32'h0, 32'h1, 32'h2},
        4'b1011, 3, 1'b1);
    cyc(4'b0001, 16'h0000, V0, 4'b0001, -1, 1'b1);
    cyc(4'b1010, 16'hC0B0, {32'hCC, 32'h0, 32'hBB, 32'h0},
        4'b0010, 1, 1'b1);
    cyc(4'b1111, 16'h4321, VA, 4'b0100, 2, 1'b1);

    @(negedge clk);
    bus.req_valid = 4'b1111;
    #1;
    chk("pre_rst_ready", 32'(bus.req_ready), 32'b1000);
    #2 reset = 1'b0;
    #1;
    chk("arst_ready", 32'(bus.req_ready), 32'h0);
    chk("arst_valid", 32'(bus.broadcast_valid), 32'h0);
    chk("arst_tag", 32'(bus.broadcast_tag), 32'h0);
    chk("arst_value", bus.broadcast_value, 32'h0);
    chk("arst_src", 32'(bus.broadcast_src), 32'h0);
    chk("arst_err", 32'(bus.err_tag0), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b1;

    cyc(4'b1111, 16'h4321, VA, 4'b0001, 0, 1'b0);
    repeat (3) cyc(4'b0000, 16'h0, V0, 4'b0000, -1, 1'b0);

    budget = 10;
    while (q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("queue_drained", 32'(q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
Arbitrates the single Common Data Bus between completing functional units (add and mul reservation-station outputs).
Each cycle it grants at most one requester, round-robin, and drives a registered broadcast of (tag, value) one cycle later.
The broadcast feeds the RAT and the reservation stations.
Tag 0 is reserved as "no tag" and is never broadcast as valid.

Parameters:
N_REQ, 4, number of requesting functional units (index 0..N_REQ-1)
TAG_W, 4, tag width; tag value 0 is reserved/invalid
DATA_W, 32, result value width
ID_W, $clog2(N_REQ), width of grant index

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
req_valid  in  N_REQ  requester i has a result pending; held until accepted
req_tag  in  N_REQ*TAG_W  requester i tag, slice [i*TAG_W +: TAG_W]
req_value  in  N_REQ*DATA_W  requester i result, slice [i*DATA_W +: DATA_W]
req_ready  out  N_REQ  combinational accept; transfer occurs when req_valid[i] && req_ready[i]
broadcast_valid  out  1  registered; broadcast_tag/value are meaningful this cycle
broadcast_tag  out  TAG_W  registered broadcast tag; 0 when idle
broadcast_value  out  DATA_W  registered broadcast value; 0 when idle
broadcast_src  out  ID_W  registered index of the requester being broadcast
err_tag0  out  1  sticky; set when any requester presents valid with tag 0

Behaviour:
- State: rr_ptr (ID_W), broadcast registers, err_tag0 flag.
- Reset (reset==0, async):
  - broadcast_valid=0, broadcast_tag=0, broadcast_value=0, broadcast_src=0.
  - rr_ptr=0, err_tag0=0.
  - req_ready forced to all-zero while reset is asserted.
- Eligibility: requester i is eligible iff req_valid[i] && req_tag[i]!=0.
- Arbitration (combinational, cycle t):
  - Search eligible requesters starting at rr_ptr, incrementing mod N_REQ.
  - The first hit is the winner; req_ready[winner]=1, all other eligible requesters get ready=0.
  - At most one eligible ready per cycle.
- Tag-0 requests: req_valid[i] && req_tag[i]==0 gets req_ready[i]=1 in the same cycle (drained, never broadcast). err_tag0 <= 1 at the next edge.
  - A tag-0 drain does not block or replace the eligible winner.
  - Multiple tag-0 drains may occur in one cycle.
- Latency: winner accepted in cycle t is broadcast in cycle t+1.
  - Registers load broadcast_valid=1, tag, value, src=winner at the posedge ending t.
- Idle: no eligible requester in cycle t gives broadcast_valid=0, tag=0, value=0, src=0 in t+1. rr_ptr is unchanged.
- Pointer update: on a grant, rr_ptr <= (winner==N_REQ-1) ? 0 : winner+1. Wrap-around is explicit.
- Fairness: a continuously valid requester waits at most N_REQ-1 cycles for a grant.
- Back-to-back: a new grant is possible every cycle. The bus has no backpressure and the broadcast is always consumed.
- Requester obligations: tag and value stable while valid && !ready. Requesters deassert valid, or present a new result, the cycle after the handshake.
- Violation (valid dropped before ready): no grant to that requester, no error.
- Reset mid-operation: a transfer accepted in the cycle reset asserts is lost. Requesters must re-present after reset.
- err_tag0 clears only on reset.

Test Plan:
- Reset release, no requests: broadcast_valid=0, tag=0, value=0, src=0, rr_ptr=0 for 5 cycles. req_ready=0000 during reset.
- Single request: req_valid=0010, tag[1]=4'h5, value[1]=32'hDEAD_BEEF. Cycle t: req_ready=0010. Cycle t+1: broadcast_valid=1, tag=5, value=DEADBEEF, src=1. rr_ptr becomes 2.
- All four valid continuously (tags 1,2,3,4), rr_ptr=0: grants in order 0,1,2,3,0. Broadcast tags 1,2,3,4,1 on consecutive cycles, no bubbles.
- Wrap-around: rr_ptr=3, req_valid=1001. Grant 3 first (tag broadcast next cycle), then 0. rr_ptr 3→0→1.
- Tag-0 drain: req_valid=0101, tag[0]=0, tag[2]=7. req_ready=0101 in the same cycle. Next cycle broadcast tag=7, src=2, err_tag0=1, and it stays 1 until reset.
- Async reset mid-stream: all requesters valid, assert reset between edges. Outputs go to 0 immediately without waiting for clk. After release, the first grant goes to requester 0.
